// File: rtl/uart_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_arb_pkg
// Brief    : Shared types and constants for the UART transmit arbiter:
//            FSM state encoding, UART frame timing constants, default frame
//            length derivation and the grant index width helper.
// Revision : 1.0 - initial release
// ============================================================================
package uart_arb_pkg;

    // Arbiter FSM states, explicitly 2 bits wide
    typedef enum logic [1:0] {
        ARB   = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        LOCK  = 2'd3
    } arb_state_t;

    // UART bit period in clocks (100 MHz / 230400 baud) and bits per frame
    // (start + 8 data + parity + stop)
    localparam int BAUD_DIV   = 434;
    localparam int FRAME_BITS = 11;

    // Minimum clocks one byte occupies the line, and the default reservation:
    // the minimum rounded up to the next multiple of 100 clocks (4774 -> 4800)
    localparam int FRAME_CYCLES_MIN     = BAUD_DIV * FRAME_BITS;
    localparam int DEFAULT_FRAME_CYCLES = ((FRAME_CYCLES_MIN + 99) / 100) * 100;

    // Width of a requester index; never less than one bit
    function automatic int GRANT_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : uart_arb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker. Returns the first request at
//            or after the pointer (wrapping). With i_hold_en set, only the
//            request at the pointer position is considered.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    input  logic          i_hold_en,
    output logic [N-1:0]  o_grant,
    output logic [PW-1:0] o_idx,
    output logic          o_any
);

    localparam int c_sw = PW + 1;

    // Scan from the pointer upwards, wrapping modulo N; first hit wins
    always_comb begin : p_pick
        logic [PW:0]   w_sum;
        logic [PW-1:0] w_pos;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_sum   = '0;
        w_pos   = '0;
        if (i_hold_en) begin
            if (i_req[i_ptr]) begin
                o_grant[i_ptr] = 1'b1;
                o_idx          = i_ptr;
                o_any          = 1'b1;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                w_sum = {1'b0, i_ptr} + c_sw'(k);
                if (w_sum >= c_sw'(N)) begin
                    w_sum = w_sum - c_sw'(N);
                end
                w_pos = w_sum[PW-1:0];
                if (!o_any && i_req[w_pos]) begin
                    o_grant[w_pos] = 1'b1;
                    o_idx          = w_pos;
                    o_any          = 1'b1;
                end
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin arbiter with message locking in front of the UART
//            transmitter. Accepts one byte at a time, issues a one-cycle
//            tx_data_valid pulse and paces bytes with its own frame timer,
//            since the transmitter has no busy flag.
//            Optional macro UART_ARB_LOCK_TIMEOUT_EN: releases a lock whose
//            holder stays idle for LOCK_TIMEOUT cycles (pulses lock_abort).
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int FRAME_CYCLES = DEFAULT_FRAME_CYCLES,
    parameter int TIMER_W      = 13,
    parameter int LOCK_TIMEOUT = 8191
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [8*NUM_REQ-1:0]        req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        tx_data_valid,
    output logic [7:0]                  tx_data,
    output logic [GRANT_W(NUM_REQ)-1:0] grant_id,
    output logic                        busy,
    output logic                        lock_abort
);

    localparam int GW = GRANT_W(NUM_REQ);

    // WAIT counts down to zero, so the load value is two less than the
    // frame: one cycle spent in ISSUE, one extra for the terminal zero
    localparam logic [TIMER_W-1:0] c_frame_load = TIMER_W'(FRAME_CYCLES - 2);

    // Parameter sanity checks at elaboration
    if (FRAME_CYCLES < 3) begin : g_chk_frame_min
        $error("uart_tx_arbiter: FRAME_CYCLES must be at least 3");
    end
    if ((FRAME_CYCLES - 2) >= (2 ** TIMER_W)) begin : g_chk_frame_fit
        $error("uart_tx_arbiter: TIMER_W too narrow for FRAME_CYCLES");
    end
    if ((LOCK_TIMEOUT < 1) || (LOCK_TIMEOUT > (2 ** TIMER_W))) begin : g_chk_lock_fit
        $error("uart_tx_arbiter: LOCK_TIMEOUT out of range for TIMER_W");
    end
    if ((NUM_REQ < 2) || (NUM_REQ > 8)) begin : g_chk_num_req
        $error("uart_tx_arbiter: NUM_REQ must be 2..8");
    end

`ifdef UART_ARB_LOCK_TIMEOUT_EN
    localparam logic [TIMER_W-1:0] c_lock_load = TIMER_W'(LOCK_TIMEOUT - 1);
`endif

    arb_state_t          r_state,   w_state_nxt;
    logic [TIMER_W-1:0]  r_timer,   w_timer_nxt;
    logic [7:0]          r_tx_data, w_tx_data_nxt;
    logic [GW-1:0]       r_grant,   w_grant_nxt;
    logic [GW-1:0]       r_rr_ptr,  w_rr_ptr_nxt;
    logic                r_locked,  w_locked_nxt;
    logic                r_armed;

    logic [NUM_REQ-1:0]  w_req_en;
    logic [NUM_REQ-1:0]  w_grant_vec;
    logic [GW-1:0]       w_idx;
    logic                w_any;
    logic                w_hold;
    logic                w_pick_en;
    logic [GW-1:0]       w_pick_ptr;
    logic [GW-1:0]       w_ptr_after;

    // In LOCK the pointer is the holder and the picker only looks there.
    // r_armed keeps req_ready low while reset is held and for the first
    // cycle after release, so every output is zero during reset.
    assign w_hold      = (r_state == LOCK);
    assign w_pick_en   = r_armed && ((r_state == ARB) || (r_state == LOCK));
    assign w_pick_ptr  = w_hold ? r_grant : r_rr_ptr;
    assign w_req_en    = req_valid & {NUM_REQ{w_pick_en}};
    assign w_ptr_after = (r_grant == GW'(NUM_REQ - 1)) ? '0 : r_grant + GW'(1);

    rr_pick #(
        .N  (NUM_REQ),
        .PW (GW)
    ) u_pick (
        .i_req     (w_req_en),
        .i_ptr     (w_pick_ptr),
        .i_hold_en (w_hold),
        .o_grant   (w_grant_vec),
        .o_idx     (w_idx),
        .o_any     (w_any)
    );

    assign req_ready = w_grant_vec;
    assign tx_data   = r_tx_data;
    assign grant_id  = r_grant;
    assign busy      = (r_state != ARB);

    // Next-state and strobe logic for the arbitration FSM
    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_tx_data_nxt = r_tx_data;
        w_grant_nxt   = r_grant;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_locked_nxt  = r_locked;
        tx_data_valid = 1'b0;
        lock_abort    = 1'b0;
        case (r_state)
            ARB: begin
                if (w_any) begin
                    w_tx_data_nxt = req_data[{w_idx, 3'b000} +: 8];
                    w_grant_nxt   = w_idx;
                    w_locked_nxt  = !req_last[w_idx];
                    w_state_nxt   = ISSUE;
                end
            end
            ISSUE: begin
                tx_data_valid = 1'b1;
                w_timer_nxt   = c_frame_load;
                w_state_nxt   = WAIT;
            end
            WAIT: begin
                if (r_timer == '0) begin
                    if (r_locked) begin
                        w_state_nxt = LOCK;
`ifdef UART_ARB_LOCK_TIMEOUT_EN
                        w_timer_nxt = c_lock_load;
`endif
                    end else begin
                        w_rr_ptr_nxt = w_ptr_after;
                        w_state_nxt  = ARB;
                    end
                end else begin
                    w_timer_nxt = r_timer - TIMER_W'(1);
                end
            end
            LOCK: begin
                // A byte from the holder always beats the idle timeout
                if (w_any) begin
                    w_tx_data_nxt = req_data[{w_idx, 3'b000} +: 8];
                    w_grant_nxt   = w_idx;
                    w_locked_nxt  = !req_last[w_idx];
                    w_state_nxt   = ISSUE;
                end
`ifdef UART_ARB_LOCK_TIMEOUT_EN
                else if (r_timer == '0) begin
                    lock_abort   = 1'b1;
                    w_locked_nxt = 1'b0;
                    w_rr_ptr_nxt = w_ptr_after;
                    w_state_nxt  = ARB;
                end else begin
                    w_timer_nxt = r_timer - TIMER_W'(1);
                end
`endif
            end
            default: begin
                w_state_nxt = ARB;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ARB;
            r_timer   <= '0;
            r_tx_data <= '0;
            r_grant   <= '0;
            r_rr_ptr  <= '0;
            r_locked  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_tx_data <= w_tx_data_nxt;
            r_grant   <= w_grant_nxt;
            r_rr_ptr  <= w_rr_ptr_nxt;
            r_locked  <= w_locked_nxt;
        end
    end

    // Arming flag: first clock after reset release enables acceptance
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
        end
    end

endmodule : uart_tx_arbiter
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Directed self-checking bench for uart_tx_arbiter with a
//            scoreboard of accepted bytes checked against issued bytes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int FRAME   = 16;
    localparam int TIMER_W = 13;
    localparam int LOCK_TO = 32;
    localparam int QD      = 16;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_data_valid;
    logic [7:0]           tx_data;
    logic [1:0]           grant_id;
    logic                 busy;
    logic                 lock_abort;

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .FRAME_CYCLES (FRAME),
        .TIMER_W      (TIMER_W),
        .LOCK_TIMEOUT (LOCK_TO)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .tx_data_valid (tx_data_valid),
        .tx_data       (tx_data),
        .grant_id      (grant_id),
        .busy          (busy),
        .lock_abort    (lock_abort)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;

    // Per-requester byte queues: {last, data}
    logic [8:0] rmem [NUM_REQ][QD];
    int rhead [NUM_REQ];
    int rtail [NUM_REQ];

    // Scoreboard entries: {grant index, byte}
    logic [15:0] sb [$];
    int iss_id [$];
    int iss_cyc [$];

    int busy_cnt  = 0;
    int abort_cnt = 0;
    int abort_cyc = 0;
    int ready_per [NUM_REQ];
    int ready_cnt = 0;
    int last_ready_id = -1;
    int last_ready_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input int r, input logic [7:0] d, input logic l);
        rmem[r][rtail[r] % QD] = {l, d};
        rtail[r]++;
    endtask

    task automatic refresh_inputs();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rhead[i] < rtail[i]) begin
                req_valid[i]        = 1'b1;
                req_data[8*i +: 8]  = rmem[i][rhead[i] % QD][7:0];
                req_last[i]         = rmem[i][rhead[i] % QD][8];
            end else begin
                req_valid[i]        = 1'b0;
                req_data[8*i +: 8]  = 8'h00;
                req_last[i]         = 1'b0;
            end
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_issues(input int n, input string tag);
        int t;
        t = 0;
        while (iss_id.size() < n && t < 2000) begin
            @(posedge clk);
            t++;
        end
        #2;
        check({tag, "_reached"}, 32'(iss_id.size() >= n), 1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Requester model: a handshake seen before the edge retires the byte
    // after the edge and the next queued byte is presented
    initial begin
        logic [NUM_REQ-1:0] hs;
        for (int i = 0; i < NUM_REQ; i++) begin
            rhead[i] = 0;
            rtail[i] = 0;
        end
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            hs = req_valid & req_ready;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (hs[i]) sb.push_back({8'(i), req_data[8*i +: 8]});
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (hs[i]) rhead[i]++;
            end
            refresh_inputs();
        end
    end

    // Output monitor: handshake legality, issue checking, event counters
    initial begin
        logic [15:0] e;
        for (int i = 0; i < NUM_REQ; i++) ready_per[i] = 0;
        forever begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (lock_abort) begin
                abort_cnt++;
                abort_cyc = cyc;
            end
            if (req_ready != '0) begin
                check("ready_onehot", 32'($onehot(req_ready)), 1);
                check("ready_without_valid", 32'(req_ready & ~req_valid), 0);
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (req_ready[i]) begin
                        ready_per[i]++;
                        ready_cnt++;
                        last_ready_id  = i;
                        last_ready_cyc = cyc;
                    end
                end
            end
            if (tx_data_valid) begin
                check("issue_without_accept", 32'(sb.size() == 0), 0);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("issue_data", 32'(tx_data), 32'(e[7:0]));
                    check("issue_grant", 32'(grant_id), 32'(e[15:8]));
                end
                iss_id.push_back(int'(grant_id));
                iss_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        int n0;
        int rc0;
        int rp0;
        int ab0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_valid", 32'(tx_data_valid), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_grant", 32'(grant_id), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_abort", 32'(lock_abort), 0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_cycles(FRAME + 4);

        // Single byte from requester 2; busy covers ISSUE plus FRAME-1 WAIT cycles
        n0 = iss_id.size();
        rc0 = ready_cnt;
        busy_cnt = 0;
        push_byte(2, 8'h5A, 1'b1);
        wait_issues(n0 + 1, "single");
        wait_cycles(FRAME + 4);
        check("single_ready_id", 32'(last_ready_id), 2);
        check("single_ready_cnt", 32'(ready_cnt - rc0), 1);
        check("single_issue_lat", 32'(iss_cyc[n0] - last_ready_cyc), 1);
        check("single_grant", 32'(iss_id[n0]), 2);
        check("single_busy_len", 32'(busy_cnt), FRAME);
        check("single_hold_data", 32'(tx_data), 32'h5A);
        check("single_idle", 32'(busy), 0);

        // Round robin from pointer 0 after reset: order 0,1,3,0 at FRAME+1 spacing
        pulse_reset();
        wait_cycles(FRAME + 4);
        n0 = iss_id.size();
        push_byte(0, 8'hA0, 1'b1);
        push_byte(0, 8'hA1, 1'b1);
        push_byte(1, 8'hB0, 1'b1);
        push_byte(3, 8'hD0, 1'b1);
        wait_issues(n0 + 4, "rr");
        check("rr_order0", 32'(iss_id[n0]), 0);
        check("rr_order1", 32'(iss_id[n0 + 1]), 1);
        check("rr_order2", 32'(iss_id[n0 + 2]), 3);
        check("rr_order3", 32'(iss_id[n0 + 3]), 0);
        for (int k = 1; k < 4; k++) begin
            check("rr_spacing", 32'(iss_cyc[n0 + k] - iss_cyc[n0 + k - 1]), FRAME + 1);
        end
        wait_cycles(FRAME + 4);

        // Locked message from requester 1 while requester 0 waits (pointer is 1)
        n0 = iss_id.size();
        rp0 = ready_per[0];
        push_byte(1, 8'h10, 1'b0);
        push_byte(1, 8'h11, 1'b0);
        push_byte(1, 8'h12, 1'b1);
        push_byte(0, 8'h20, 1'b1);
        wait_issues(n0 + 3, "lock_msg");
        check("lock_no_ready0", 32'(ready_per[0] - rp0), 0);
        wait_issues(n0 + 4, "lock_after");
        check("lock_order0", 32'(iss_id[n0]), 1);
        check("lock_order1", 32'(iss_id[n0 + 1]), 1);
        check("lock_order2", 32'(iss_id[n0 + 2]), 1);
        check("lock_order3", 32'(iss_id[n0 + 3]), 0);
        check("lock_spacing", 32'(iss_cyc[n0 + 1] - iss_cyc[n0]), FRAME + 1);
        wait_cycles(FRAME + 4);

        // Holder stall: requester 1 locks (pointer is 1) and then goes idle
        n0 = iss_id.size();
        ab0 = abort_cnt;
        push_byte(1, 8'h30, 1'b0);
        push_byte(0, 8'h40, 1'b1);
        wait_issues(n0 + 1, "stall_first");
        check("stall_first_id", 32'(iss_id[n0]), 1);
`ifdef UART_ARB_LOCK_TIMEOUT_EN
        // Abort in the LOCK_TO-th LOCK cycle; LOCK begins FRAME cycles after issue
        wait_issues(n0 + 2, "abort_next");
        check("abort_count", 32'(abort_cnt - ab0), 1);
        check("abort_cycle", 32'(abort_cyc - iss_cyc[n0]), FRAME + LOCK_TO - 1);
        check("abort_next_id", 32'(iss_id[n0 + 1]), 0);
        check("abort_next_lat", 32'(iss_cyc[n0 + 1] - abort_cyc), 2);
        push_byte(1, 8'h31, 1'b1);
        wait_issues(n0 + 3, "abort_resume");
        check("abort_resume_id", 32'(iss_id[n0 + 2]), 1);
`else
        rp0 = ready_per[0];
        wait_cycles(100 + FRAME);
        check("stall_no_issue", 32'(iss_id.size() - n0), 1);
        check("stall_starve0", 32'(ready_per[0] - rp0), 0);
        check("stall_busy", 32'(busy), 1);
        check("stall_no_abort", 32'(abort_cnt - ab0), 0);
        push_byte(1, 8'h31, 1'b1);
        wait_issues(n0 + 3, "stall_resume");
        check("stall_resume_id", 32'(iss_id[n0 + 1]), 1);
        check("stall_then0", 32'(iss_id[n0 + 2]), 0);
`endif
        wait_cycles(FRAME + 4);

        // Reset while WAIT timer is 5: without reset requester 3 would win next
        n0 = iss_id.size();
        push_byte(1, 8'h50, 1'b1);
        wait_issues(n0 + 1, "mid_first");
        push_byte(1, 8'h51, 1'b1);
        push_byte(3, 8'h53, 1'b1);
        while (cyc < iss_cyc[n0] + 10) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_tx_valid", 32'(tx_data_valid), 0);
        check("mid_rst_tx_data", 32'(tx_data), 0);
        check("mid_rst_grant", 32'(grant_id), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_ready", 32'(req_ready), 0);
        check("mid_rst_abort", 32'(lock_abort), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        wait_issues(n0 + 2, "mid_after");
        check("mid_after_id", 32'(iss_id[n0 + 1]), 1);
        wait_issues(n0 + 3, "mid_second");
        check("mid_second_id", 32'(iss_id[n0 + 2]), 3);
        wait_cycles(FRAME + 4);

        check("sb_drained", 32'(sb.size()), 0);
`ifndef UART_ARB_LOCK_TIMEOUT_EN
        check("never_abort", 32'(abort_cnt), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_uart_tx_arbiter
`default_nettype wire
